// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment scan driver: code width and
// active-high segment patterns ordered {a,b,c,d,e,f,g}.
package seven_segment_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational code-to-segment decoder producing an active-high pattern.
// Codes 10..15 only light up when hex_en is set; blank forces all segments off.
module seven_segment_decoder
    import seven_segment_pkg::*;
(
    input  logic [DIGIT_W-1:0] code,
    input  logic               hex_en,
    input  logic               blank,
    output logic [6:0]         pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        if (!blank) begin
            case (code)
                4'd0:  pattern = SEG_0;
                4'd1:  pattern = SEG_1;
                4'd2:  pattern = SEG_2;
                4'd3:  pattern = SEG_3;
                4'd4:  pattern = SEG_4;
                4'd5:  pattern = SEG_5;
                4'd6:  pattern = SEG_6;
                4'd7:  pattern = SEG_7;
                4'd8:  pattern = SEG_8;
                4'd9:  pattern = SEG_9;
                4'd10: pattern = hex_en ? SEG_A : SEG_BLANK;
                4'd11: pattern = hex_en ? SEG_B : SEG_BLANK;
                4'd12: pattern = hex_en ? SEG_C : SEG_BLANK;
                4'd13: pattern = hex_en ? SEG_D : SEG_BLANK;
                4'd14: pattern = hex_en ? SEG_E : SEG_BLANK;
                4'd15: pattern = hex_en ? SEG_F : SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed N-digit seven-segment driver with shadow registers,
// leading-zero suppression, output polarity control and a frame strobe.
module seven_segment_scan
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int HEX_MODE       = 0,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          blank_lz,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_tick
);

    localparam int PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                      : {NUM_DIGITS{1'b0}};

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]              dps_q, dps_d;
    logic [PRE_W-1:0]                   prescaler_q, prescaler_d;
    logic [IDX_W-1:0]                   index_q, index_d;
    logic                               wrap_pend_q, wrap_pend_d;
    logic [6:0]                         seg_q, seg_d;
    logic                               dp_q, dp_d;
    logic [NUM_DIGITS-1:0]              an_q, an_d;
    logic                               frame_tick_q, frame_tick_d;

    logic                               slot_end;
    logic                               frame_wrap;
    logic [NUM_DIGITS-1:0]              zero_tail;
    logic                               lz_blank;
    logic [DIGIT_W-1:0]                 cur_code;
    logic [6:0]                         pattern;

    always_comb begin
        slot_end    = enable && (prescaler_q == PRE_LAST);
        frame_wrap  = slot_end && (index_q == IDX_LAST);
        prescaler_d = prescaler_q;
        index_d     = index_q;
        if (enable) begin
            prescaler_d = slot_end ? '0 : prescaler_q + 1'b1;
        end
        if (slot_end) begin
            index_d = frame_wrap ? '0 : index_q + 1'b1;
        end
        // Delayed by one edge so the strobe lines up with an's return to digit 0.
        wrap_pend_d = frame_wrap;
        digits_d    = load ? digits_in : digits_q;
        dps_d       = load ? dp_in : dps_q;
    end

    // zero_tail[i] is set when digits i..NUM_DIGITS-1 are all zero.
    always_comb begin
        logic run;
        run       = 1'b1;
        zero_tail = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run          = run && (digits_q[i] == '0);
            zero_tail[i] = run;
        end
    end

    always_comb begin
        cur_code = digits_q[index_q];
        lz_blank = blank_lz && (index_q != '0) && zero_tail[index_q];
    end

    seven_segment_decoder u_decoder (
        .code    (cur_code),
        .hex_en  (HEX_MODE != 0),
        .blank   (lz_blank),
        .pattern (pattern)
    );

    always_comb begin
        seg_d        = SEG_OFF;
        dp_d         = DP_OFF;
        an_d         = AN_OFF;
        frame_tick_d = 1'b0;
        if (enable) begin
            seg_d        = pattern ^ SEG_OFF;
            dp_d         = dps_q[index_q] ^ DP_OFF;
            an_d         = (NUM_DIGITS'(1) << index_q) ^ AN_OFF;
            frame_tick_d = wrap_pend_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q     <= '0;
            dps_q        <= '0;
            prescaler_q  <= '0;
            index_q      <= '0;
            wrap_pend_q  <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            digits_q     <= digits_d;
            dps_q        <= dps_d;
            prescaler_q  <= prescaler_d;
            index_q      <= index_d;
            wrap_pend_q  <= wrap_pend_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Scoreboard bench: two parameterisations driven in parallel, expected outputs
// come from a tick-count reference model and are checked by a separate monitor.
module tb_seven_segment_scan;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          load;
    logic [15:0]   digits_in;
    logic [3:0]    dp_in;
    logic          blank_lz;
    logic [6:0]    seg_a, seg_b;
    logic          dp_a, dp_b;
    logic [3:0]    an_a, an_b;
    logic          ft_a, ft_b;

    seven_segment_scan #(
        .NUM_DIGITS(N), .REFRESH_DIV(DIV), .HEX_MODE(1),
        .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
    ) dut_hi (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .blank_lz(blank_lz),
        .seg(seg_a), .dp(dp_a), .an(an_a), .frame_tick(ft_a)
    );

    seven_segment_scan #(
        .NUM_DIGITS(N), .REFRESH_DIV(DIV), .HEX_MODE(0),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut_lo (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .blank_lz(blank_lz),
        .seg(seg_b), .dp(dp_b), .an(an_b), .frame_tick(ft_b)
    );

    typedef struct {
        logic [6:0] seg_a;
        logic       dp_a;
        logic [3:0] an_a;
        logic       ft_a;
        logic [6:0] seg_b;
        logic       dp_b;
        logic [3:0] an_b;
        logic       ft_b;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: enabled cycles since reset and the shadow contents.
    int   ticks = 0;
    int   sh[N];
    bit   shdp[N];
    bit   wrap_prev = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int code, input bit hex);
        logic [6:0] t[16];
        t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        if (code >= 10 && !hex) return 7'b0000000;
        return t[code];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, expv);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("seg_hi",   32'(seg_a), 32'(e.seg_a));
                chk("dp_hi",    32'(dp_a),  32'(e.dp_a));
                chk("an_hi",    32'(an_a),  32'(e.an_a));
                chk("frame_hi", 32'(ft_a),  32'(e.ft_a));
                chk("seg_lo",   32'(seg_b), 32'(e.seg_b));
                chk("dp_lo",    32'(dp_b),  32'(e.dp_b));
                chk("an_lo",    32'(an_b),  32'(e.an_b));
                chk("frame_lo", 32'(ft_b),  32'(e.ft_b));
            end
        end
    end

    // Predicts the outputs after the coming edge from the inputs now applied.
    task automatic model_step();
        exp_t e;
        int   d;
        bit   lzb;
        e = '{seg_a: 7'h00, dp_a: 1'b0, an_a: 4'h0, ft_a: 1'b0,
              seg_b: 7'h7f, dp_b: 1'b1, an_b: 4'hf, ft_b: 1'b0};
        if (rst) begin
            ticks = 0;
            wrap_prev = 0;
            for (int i = 0; i < N; i++) begin
                sh[i] = 0;
                shdp[i] = 0;
            end
        end else begin
            if (enable) begin
                d   = (ticks / DIV) % N;
                lzb = blank_lz && (d > 0);
                for (int i = d; i < N; i++) if (sh[i] != 0) lzb = 0;
                e.seg_a = lzb ? 7'h00 : glyph(sh[d], 1);
                e.seg_b = ~(lzb ? 7'h00 : glyph(sh[d], 0));
                e.dp_a  = shdp[d];
                e.dp_b  = ~shdp[d];
                e.an_a  = 4'(1 << d);
                e.an_b  = ~4'(1 << d);
                e.ft_a  = wrap_prev;
                e.ft_b  = wrap_prev;
                wrap_prev = (ticks % (DIV * N)) == (DIV * N - 1);
                ticks++;
            end else begin
                wrap_prev = 0;
            end
            if (load) begin
                for (int i = 0; i < N; i++) begin
                    sh[i]   = int'(digits_in[4*i +: 4]);
                    shdp[i] = dp_in[i];
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit r, input bit en, input bit ld,
                         input logic [15:0] dv, input logic [3:0] pv, input bit bl);
        @(negedge clk);
        rst       = r;
        enable    = en;
        load      = ld;
        digits_in = dv;
        dp_in     = pv;
        blank_lz  = bl;
        model_step();
    endtask

    task automatic idle(input int n, input bit bl);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, digits_in, dp_in, bl);
    endtask

    initial begin
        logic [15:0] masks[5];
        logic [15:0] rd;
        masks = '{16'hffff, 16'h0fff, 16'h00ff, 16'h000f, 16'h0000};
        rst = 1'b1; enable = 1'b1; load = 1'b0;
        digits_in = '0; dp_in = '0; blank_lz = 1'b0;

        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 16'h0, 4'h0, 0);
        idle(3, 0);
        cycle(0, 1, 1, 16'h4321, 4'b0100, 0);
        idle(40, 0);
        cycle(0, 1, 1, 16'h00af, 4'b0000, 0);
        idle(20, 0);
        idle(20, 1);
        cycle(0, 1, 1, 16'h0000, 4'b0011, 1);
        idle(20, 1);
        cycle(0, 1, 1, 16'h0008, 4'b0001, 0);
        idle(20, 0);

        idle(2, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, digits_in, dp_in, 0);
        idle(20, 0);

        while ((ticks % DIV) != DIV - 1) idle(1, 0);
        cycle(0, 1, 1, 16'h9876, 4'b1010, 0);
        idle(8, 0);

        while (((ticks / DIV) % N) != 2) idle(1, 0);
        idle(1, 0);
        cycle(1, 1, 0, digits_in, dp_in, 0);
        idle(10, 0);

        for (int i = 0; i < 3000; i++) begin
            rd = 16'($urandom) & masks[$urandom_range(0, 4)];
            cycle(($urandom % 200) == 0, ($urandom % 10) != 0, ($urandom % 8) == 0,
                  rd, 4'($urandom), 1'($urandom));
        end

        idle(3, 0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
